sfm_vect_addmul_feeder: RTL
===========================

// Module: sfm_vect_addmul_feeder
// PURPOSE
// Upstream driver for the vector add/mul FMA stage; the sending side of its operand interface.
// Packs a programmed-length element stream into VECT_WIDTH-lane beats, generates lane strobes and a
// last flag, and supplies the held scalar operand with its scal_valid qualifier.
// Observes the result handshake, counts in-flight beats and flags job completion to the controller.
// PARAMETERS
// FPFORMAT         FP16ALT  fpnew_pkg::fp_format_e; WIDTH = fpnew_pkg::fp_width(FPFORMAT)
// VECT_WIDTH       1        lanes per beat
// LEN_WIDTH        16       width of element-count field
// MAX_OUTSTANDING  4        max beats issued but not yet returned (>=1); CW = $clog2(MAX_OUTSTANDING+1)
// PORTS
// clk_i          in   1                 clock
// rst_ni         in   1                 asynchronous active-low reset
// clear_i        in   1                 synchronous soft clear
// start_i        in   1                 start job (sampled in IDLE only)
// len_i          in   LEN_WIDTH         element count of job, sampled with start_i
// scal_i         in   WIDTH             scalar operand
// scal_valid_i   in   1                 scalar operand valid
// scal_ready_o   out  1                 scalar operand accepted
// in_valid_i     in   1                 element-vector beat valid
// in_vect_i      in   VECT_WIDTH*WIDTH  element-vector beat
// in_ready_o     out  1                 element-vector beat accepted
// vect_o         out  VECT_WIDTH*WIDTH  operand vector to FMA stage
// strb_o         out  VECT_WIDTH        lane strobes
// last_o         out  1                 tag: final beat of job
// valid_o        out  1                 operand beat valid
// ready_i        in   1                 FMA stage ready
// scal_o         out  WIDTH             held scalar operand
// scal_valid_o   out  1                 scalar operand valid
// res_valid_i    in   1                 result valid (observed only)
// res_ready_i    in   1                 result consumer ready (observed only)
// busy_o         out  1                 job in progress (state != IDLE)
// done_o         out  1                 one-cycle pulse: job complete
// BEHAVIOUR
// - Reset (rst_ni low, async): state IDLE; rem = 0; outstanding cnt = 0; scalar register = 0.
//   All outputs 0, incl. vect_o/strb_o/last_o.
// - FSM: IDLE -> SCAL on start_i (rem <= len_i); IDLE -> IDLE with done_o=1 next cycle if len_i == 0.
//   SCAL: scal_ready_o = 1; on scal_valid_i & scal_ready_o latch scal_i, -> RUN.
//   RUN: issue beats; handshake with last_o=1 -> DRAIN.
//   DRAIN: when cnt == 0 (including cnt reaching 0 this cycle) pulse done_o, -> IDLE.
// - scal_valid_o = 1 in RUN and DRAIN; scal_o holds the latched value, stable until next job's SCAL.
// - RUN, combinational pass-through, 0-cycle latency:
//   valid_o = in_valid_i & (cnt < MAX_OUTSTANDING); in_ready_o = ready_i & (cnt < MAX_OUTSTANDING).
//   vect_o = in_vect_i.
//   strb_o[i] = (i < rem); last_o = (rem <= VECT_WIDTH).
//   Outside RUN: valid_o = in_ready_o = 0.
// - Issue handshake (valid_o & ready_i): rem <= rem - min(rem, VECT_WIDTH).
// - valid_o must not depend on ready_i; once asserted, vect_o/strb_o/last_o hold until handshake.
// - cnt: +1 on issue handshake, -1 on res_valid_i & res_ready_i, unchanged when both occur.
//   Never exceeds MAX_OUTSTANDING and never underflows; a return at cnt == 0 is ignored.
// - start_i outside IDLE is ignored. Masked lanes still carry in_vect_i data.
// - clear_i: next cycle state IDLE, rem = cnt = 0, no done_o. Scalar register is kept.
//   Takes priority over all other events in the same cycle.
// TESTING
// - VW=4, len=10, scal=0x3F80, ready_i=1:
//   3 beats, strb 1111/1111/0011, last_o only on beat 3, scal_valid_o high from RUN.
//   done_o pulses one cycle after 3rd result returns.
// - len=0 start -> no scal_ready_o, no valid_o; done_o = 1 for exactly one cycle, busy_o low after.
// - ready_i held low 5 cycles mid-job -> valid_o stays 1, vect_o/strb_o stable, rem unchanged.
// - MAX_OUTSTANDING=2, no results returned -> after 2 beats in_ready_o=valid_o=0.
//   One res handshake reopens exactly one beat.
// - Issue and result handshake in the same cycle with cnt=1 -> cnt stays 1.
//   Last result in DRAIN -> done_o the cycle cnt hits 0.
// - clear_i in RUN after 1 of 3 beats -> IDLE next cycle, busy_o=0, no done_o.
//   New start then runs normally. Async rst_ni mid-DRAIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/sfm_vect_addmul_feeder.sv
// sfm_vect_addmul_feeder: packs a length-programmed element stream into strobed beats for the
// vector add/mul FMA stage, holds the scalar operand and tracks in-flight beats to signal job completion.
module sfm_vect_addmul_feeder #(
    parameter int WIDTH           = 16,
    parameter int VECT_WIDTH      = 1,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [LEN_WIDTH-1:0]        len_i,
    input  logic [WIDTH-1:0]            scal_i,
    input  logic                        scal_valid_i,
    output logic                        scal_ready_o,
    input  logic                        in_valid_i,
    input  logic [VECT_WIDTH*WIDTH-1:0] in_vect_i,
    output logic                        in_ready_o,
    output logic [VECT_WIDTH*WIDTH-1:0] vect_o,
    output logic [VECT_WIDTH-1:0]       strb_o,
    output logic                        last_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [WIDTH-1:0]            scal_o,
    output logic                        scal_valid_o,
    input  logic                        res_valid_i,
    input  logic                        res_ready_i,
    output logic                        busy_o,
    output logic                        done_o
);
    typedef enum logic [1:0] {IDLE, SCAL, RUN, DRAIN} state_e;

    localparam logic [CW-1:0]        MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [LEN_WIDTH-1:0] VW_LEN  = LEN_WIDTH'(VECT_WIDTH);

    state_e               state, state_nxt;
    logic [LEN_WIDTH-1:0] rem, rem_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [WIDTH-1:0]     scal_q;
    logic                 done_q, done_nxt;
    logic                 run, room, issue, ret;

    always_comb begin
        run          = state == RUN;
        room         = cnt < MAX_CNT;
        valid_o      = run & in_valid_i & room;
        in_ready_o   = run & ready_i & room;
        issue        = valid_o & ready_i;
        ret          = res_valid_i & res_ready_i & (cnt != '0);
        vect_o       = run ? in_vect_i : '0;
        last_o       = run & (rem <= VW_LEN);
        strb_o       = '0;
        for (int i = 0; i < VECT_WIDTH; i++) strb_o[i] = run & (LEN_WIDTH'(i) < rem);
        scal_ready_o = state == SCAL;
        scal_valid_o = (state == RUN) | (state == DRAIN);
        scal_o       = scal_q;
        busy_o       = state != IDLE;
        done_o       = done_q;
        cnt_nxt      = cnt + CW'(issue) - CW'(ret);
        rem_nxt      = issue ? rem - (last_o ? rem : VW_LEN) : rem;
        state_nxt    = state;
        done_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                // A zero-length job completes without ever touching the scalar or element ports
                if (start_i && len_i == '0) done_nxt = 1'b1;
                else if (start_i) begin
                    state_nxt = SCAL;
                    rem_nxt   = len_i;
                end
            end
            SCAL:  state_nxt = scal_valid_i ? RUN : SCAL;
            RUN:   state_nxt = (issue && last_o) ? DRAIN : RUN;
            DRAIN: begin
                state_nxt = (cnt_nxt == '0) ? IDLE : DRAIN;
                done_nxt  = cnt_nxt == '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            rem    <= '0;
            cnt    <= '0;
            scal_q <= '0;
            done_q <= 1'b0;
        end else if (clear_i) begin
            state  <= IDLE;
            rem    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
            if (state == SCAL && scal_valid_i) scal_q <= scal_i;
        end
    end
endmodule
